// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among n_req requesters:
// one access per cycle, read data routed back to its requester after a fixed latency.
module sram_port_arbiter #(
  parameter int n_req        = 4,
  parameter int data_width   = 16,
  parameter int addr_width   = 16,
  parameter int read_latency = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [n_req-1:0]            req,
  input  logic [n_req-1:0]            req_write,
  input  logic [n_req*addr_width-1:0] req_addr,
  input  logic [n_req*data_width-1:0] req_wdata,
  output logic [n_req-1:0]            grant,
  output logic [n_req-1:0]            rvalid,
  output logic [data_width-1:0]       rdata,
  output logic [addr_width-1:0]       sram_addr,
  output logic [data_width-1:0]       sram_wdata,
  output logic                        sram_we,
  output logic                        sram_re,
  input  logic [data_width-1:0]       sram_rdata,
  output logic                        busy
);
  localparam int idx_w = (n_req > 1) ? $clog2(n_req) : 1;

  logic [idx_w-1:0]  ptr, gidx;
  logic              found;
  logic [read_latency:0] vld_pipe;
  logic [idx_w-1:0]  tag_pipe [read_latency+1];

  // Search from the pointer upward with wrap; first set request wins.
  always_comb begin : arb
    int idx;
    logic [idx_w-1:0] cand;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    if (enable && !reset) begin
      for (int k = 0; k < n_req; k++) begin
        idx = int'(ptr) + k;
        if (idx >= n_req) idx = idx - n_req;
        cand = idx[idx_w-1:0];
        if (!found && req[cand]) begin
          found       = 1'b1;
          gidx        = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      vld_pipe   <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      for (int j = 0; j <= read_latency; j++) tag_pipe[j] <= '0;
    end else begin
      sram_we <= found & req_write[gidx];
      sram_re <= found & ~req_write[gidx];
      if (found) begin
        ptr        <= (gidx == idx_w'(n_req - 1)) ? '0 : gidx + 1'b1;
        sram_addr  <= req_addr[gidx*addr_width +: addr_width];
        sram_wdata <= req_wdata[gidx*data_width +: data_width];
      end
      // Tag stage read_latency lines up with the cycle sram_rdata is valid.
      vld_pipe    <= {vld_pipe[read_latency-1:0], found & ~req_write[gidx]};
      tag_pipe[0] <= gidx;
      for (int j = 1; j <= read_latency; j++) tag_pipe[j] <= tag_pipe[j-1];
      rvalid <= '0;
      if (vld_pipe[read_latency]) begin
        rvalid[tag_pipe[read_latency]] <= 1'b1;
        rdata                          <= sram_rdata;
      end
    end
  end

  assign busy = (|req) | (|vld_pipe) | sram_we | sram_re;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a per-cycle transaction model plus
// hand-computed expectations for the key scenarios.
module tb_sram_port_arbiter;
  localparam int NR = 4, DW = 16, AW = 16, RL = 2, MAXC = 512;

  logic clk = 1'b0;
  logic reset, enable;
  logic [NR-1:0] req, req_write, grant, rvalid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0] rdata, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;
  logic sram_we, sram_re, busy;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.n_req(NR), .data_width(DW), .addr_width(AW), .read_latency(RL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .rvalid(rvalid),
    .rdata(rdata), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_re(sram_re), .sram_rdata(sram_rdata), .busy(busy));

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  // SRAM: unwritten words read as dflt(addr); data appears RL cycles after sram_re.
  bit [DW-1:0] s_mem [65536];
  bit          s_set [65536];
  logic [DW-1:0] s_p1;
  always @(posedge clk) begin
    if (sram_we) begin
      s_mem[sram_addr] <= sram_wdata;
      s_set[sram_addr] <= 1'b1;
    end
    s_p1       <= s_set[sram_addr] ? s_mem[sram_addr] : dflt(sram_addr);
    sram_rdata <= s_p1;
  end

  // Model: expected outputs per absolute cycle, filled in when a grant is predicted.
  int mptr = 0;
  bit [DW-1:0] m_mem [65536];
  bit          m_set [65536];
  bit          e_we [MAXC], e_re [MAXC];
  bit [AW-1:0] e_addr [MAXC];
  bit [DW-1:0] e_wd [MAXC], e_rd [MAXC];
  bit [NR-1:0] e_rv [MAXC];
  int          e_fl [MAXC];
  logic [NR-1:0] o_grant [MAXC], o_rv [MAXC];
  logic [DW-1:0] o_rd [MAXC];
  logic [AW-1:0] o_addr [MAXC];
  logic          o_we [MAXC], o_re [MAXC], o_busy [MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    logic [NR-1:0] mg;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int g, idx, c;
    c = cyc;
    o_grant[c] = grant; o_rv[c] = rvalid; o_rd[c] = rdata; o_addr[c] = sram_addr;
    o_we[c] = sram_we;  o_re[c] = sram_re; o_busy[c] = busy;
    g = -1;
    if (!reset && enable)
      for (int k = 0; k < NR; k++) begin
        idx = (mptr + k) % NR;
        if (g < 0 && req[idx[1:0]]) g = idx;
      end
    mg = (g >= 0) ? (NR'(1) << g) : '0;
    chk("grant", 32'(grant), 32'(mg));
    chk("sram_we", 32'(sram_we), 32'(e_we[c]));
    chk("sram_re", 32'(sram_re), 32'(e_re[c]));
    if (e_we[c] || e_re[c]) chk("sram_addr", 32'(sram_addr), 32'(e_addr[c]));
    if (e_we[c]) chk("sram_wdata", 32'(sram_wdata), 32'(e_wd[c]));
    chk("rvalid", 32'(rvalid), 32'(e_rv[c]));
    if (e_rv[c] != 0) chk("rdata", 32'(rdata), 32'(e_rd[c]));
    chk("busy", 32'(busy), 32'((req != 0) || (e_fl[c] > 0) || e_we[c] || e_re[c]));
    chk("we_re_excl", 32'(sram_we & sram_re), 32'(0));
    if (reset) begin
      mptr = 0;
      for (int j = c + 1; j < MAXC; j++) begin
        e_we[j] = 0; e_re[j] = 0; e_rv[j] = '0; e_fl[j] = 0;
      end
    end else if (g >= 0) begin
      mptr = (g + 1) % NR;
      a  = req_addr[g*AW +: AW];
      wd = req_wdata[g*DW +: DW];
      e_addr[c+1] = a;
      if (req_write[g[1:0]]) begin
        m_mem[a] = wd; m_set[a] = 1'b1;
        e_we[c+1] = 1'b1; e_wd[c+1] = wd;
      end else begin
        e_re[c+1] = 1'b1;
        e_rv[c+2+RL] = mg;
        e_rd[c+2+RL] = m_set[a] ? m_mem[a] : dflt(a);
        for (int j = c + 1; j <= c + 1 + RL; j++) e_fl[j]++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write = (req_write & ~(NR'(1) << i)) | (NR'(wr) << i);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int t;
    logic [NR-1:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b1; enable = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    repeat (3) step();
    chk("rst_grant", 32'(o_grant[2]), 32'(0));
    chk("rst_rvalid", 32'(o_rv[2]), 32'(0));
    chk("rst_we", 32'(o_we[2]), 32'(0));
    chk("rst_rdata", 32'(o_rd[2]), 32'(0));
    reset = 1'b0;

    // single read
    set_req(0, 0, 16'h0010, 16'h0); req = 4'b0001; t = cyc; step();
    req = '0; repeat (6) step();
    chk("single_grant", 32'(o_grant[t]), 32'h1);
    chk("single_re", 32'(o_re[t+1]), 32'h1);
    chk("single_addr", 32'(o_addr[t+1]), 32'h0010);
    chk("single_early", 32'(o_rv[t+3]), 32'h0);
    chk("single_rvalid", 32'(o_rv[t+4]), 32'h1);
    chk("single_rdata", 32'(o_rd[t+4]), 32'h1234);

    // move pointer to 0, then round-robin over four readers
    set_req(3, 0, 16'h0030, 16'h0); req = 4'b1000; step();
    req = '0; step();
    for (int i = 0; i < NR; i++) set_req(i, 0, 16'h0020 + 16'(i), 16'h0);
    req = 4'b1111; t = cyc; repeat (5) step();
    req = '0; repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", 32'(o_grant[t+i]), 32'(rr_exp[i]));
      chk("rr_rvalid", 32'(o_rv[t+4+i]), 32'(rr_exp[i]));
    end
    chk("rr_rdata0", 32'(o_rd[t+4]), 32'h5A7A);
    chk("rr_rdata1", 32'(o_rd[t+5]), 32'h5A7B);

    // pointer to 2, then req=0011 wraps to 0 first
    set_req(1, 0, 16'h0040, 16'h0); req = 4'b0010; step();
    req = '0; step();
    set_req(0, 0, 16'h0050, 16'h0); set_req(1, 0, 16'h0051, 16'h0);
    req = 4'b0011; t = cyc; step();
    req = 4'b0010; step();
    req = '0; repeat (5) step();
    chk("wrap_grant0", 32'(o_grant[t]), 32'h1);
    chk("wrap_grant1", 32'(o_grant[t+1]), 32'h2);

    // write then read of the same address on consecutive grants
    set_req(0, 1, 16'h0100, 16'hBEEF); set_req(1, 0, 16'h0100, 16'h0);
    req = 4'b0001; t = cyc; step();
    req = 4'b0010; step();
    req = '0; repeat (6) step();
    chk("haz_we", 32'(o_we[t+1]), 32'h1);
    chk("haz_re", 32'(o_re[t+2]), 32'h1);
    chk("haz_rvalid", 32'(o_rv[t+5]), 32'h2);
    chk("haz_rdata", 32'(o_rd[t+5]), 32'hBEEF);

    // pointer to 0, then hold requests with enable low
    set_req(3, 0, 16'h0060, 16'h0); req = 4'b1000; step();
    req = '0; step();
    set_req(0, 0, 16'h0070, 16'h0); set_req(2, 0, 16'h0072, 16'h0);
    enable = 1'b0; req = 4'b0101; t = cyc; repeat (10) step();
    enable = 1'b1; step();
    req = 4'b0100; step();
    req = '0; repeat (6) step();
    for (int i = 0; i < 10; i++) begin
      chk("dis_grant", 32'(o_grant[t+i]), 32'h0);
      chk("dis_busy", 32'(o_busy[t+i]), 32'h1);
    end
    chk("en_grant0", 32'(o_grant[t+10]), 32'h1);
    chk("en_grant1", 32'(o_grant[t+11]), 32'h4);

    // reset two cycles after a read grant drops the read
    set_req(0, 0, 16'h0010, 16'h0); req = 4'b0001; t = cyc; step();
    req = '0; step();
    reset = 1'b1; step();
    reset = 1'b0;
    set_req(0, 0, 16'h0080, 16'h0); set_req(3, 0, 16'h0083, 16'h0);
    req = 4'b1001; step();
    req = 4'b1000; step();
    req = '0; repeat (6) step();
    chk("mrst_grant", 32'(o_grant[t]), 32'h1);
    chk("mrst_rv3", 32'(o_rv[t+3]), 32'h0);
    chk("mrst_rv4", 32'(o_rv[t+4]), 32'h0);
    chk("mrst_re", 32'(o_re[t+3]), 32'h0);
    chk("mrst_addr", 32'(o_addr[t+3]), 32'h0);
    chk("mrst_rdata", 32'(o_rd[t+3]), 32'h0);
    chk("mrst_grant_a", 32'(o_grant[t+3]), 32'h1);
    chk("mrst_grant_b", 32'(o_grant[t+4]), 32'h8);

    // mixed traffic over a few shared addresses
    for (int n = 0; n < 30; n++) begin
      enable = ($urandom_range(0, 3) != 0);
      req    = NR'($urandom);
      for (int i = 0; i < NR; i++)
        set_req(i, 1'($urandom), 16'h0100 + 16'($urandom_range(0, 3)), 16'($urandom));
      step();
    end
    req = '0; enable = 1'b1; repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
